fp_mult_round_pack: RTL and testbench
=====================================

# fp_mult_round_pack

Post-multiply stage of the FP32 multiplier datapath: consumes the 48-bit mantissa product from the 24x24 mantissa multiplier plus operand signs/exponents, then normalizes, rounds (round-to-nearest-even), detects overflow/underflow and packs an IEEE-754 single-precision word. It is a 4-state sequential unit with a start/done handshake, one result per 4 cycles. Subnormals are not produced: underflow flushes to signed zero.

## Interface
- No parameters. Widths fixed for FP32: 48-bit product, 8-bit exponent, 23-bit fraction.
- One clock; reset is synchronous and active-high.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- round_input_ready  in  1  start strobe; inputs valid this cycle
- product  in  48  unsigned mantissa product (hidden bits included)
- sign_a, sign_b  in  1 each  operand signs
- exp_a, exp_b  in  8 each  biased operand exponents
- result  out  32  packed FP32 {sign, exp[7:0], frac[22:0]}
- round_output_ready  out  1  one-cycle pulse: result/flags valid
- busy  out  1  high while not in IDLE
- overflow, underflow, inexact  out  1 each  status flags for the current result

## Operation
- States: IDLE -> NORM -> ROUND -> PACK -> IDLE.
- IDLE: on round_input_ready=1 capture all inputs, go NORM. Strobe in any other state is ignored (no queuing).
- Capture: sign = sign_a ^ sign_b; exp = exp_a + exp_b - 127, computed in 10-bit two's complement (range -127..383, no wrap).
- NORM: product == 0 -> zero flag set. Else if product[47]: frac = product[46:24], guard = product[23], sticky = |product[22:0], exp = exp + 1. Else: frac = product[45:23], guard = product[22], sticky = |product[21:0].
- ROUND: round_up = guard & (sticky | frac[0]). frac+round_up computed 24 bits; carry out -> frac = 0, exp = exp + 1. inexact = guard | sticky.
- PACK (priority order):
  - zero: result = {sign, 31'b0}; all flags 0.
  - exp >= 255 (signed): result = {sign, 8'hFF, 23'b0}; overflow=1, inexact=1.
  - exp <= 0 (signed): result = {sign, 31'b0}; underflow=1, inexact=1.
  - else result = {sign, exp[7:0], frac}; overflow=underflow=0.
- Product with neither bit 47 nor 46 set (non-normalized upstream operand) is handled by the bit-46 path without further shifting; no error flag.
- result and flags written only in PACK; held until next PACK or reset.

## Timing
- Reset: state IDLE, result=0, round_output_ready=0, busy=0, overflow=underflow=inexact=0. Reset wins over strobe in the same cycle; reset mid-operation aborts, no done pulse.
- Strobe sampled at edge k -> busy=1 after edge k; NORM at k+1, ROUND at k+2, PACK at k+3.
- After edge k+3: result/flags valid, round_output_ready=1 for exactly one cycle, busy=0, state IDLE.
- Latency 4 cycles strobe-to-done. A strobe in the done cycle is accepted (back-to-back, one result per 4 cycles).
- Strobe at edges k+1..k+3 is dropped; the in-flight result is unaffected.

## Test plan
- 1.0*1.0: product=48'h400000000000, exp 127/127, signs 0/0 -> result 32'h3F800000, flags 0, done exactly 4 cycles after strobe.
- 1.5*(-1.5): product=48'h900000000000, exp 127/127, signs 0/1 -> 32'hC0100000 (bit-47 normalize path), inexact=0.
- Rounding: product=48'h400000C00000 -> 32'h3F800002 inexact=1 (tie, lsb 1, round up); 48'h400000400000 -> 32'h3F800000 inexact=1 (tie to even); 48'h7FFFFFC00000 -> 32'h40000000 (round carry into exponent).
- Range: exp 254/254, product 48'h400000000000 -> 32'h7F800000 overflow=1; exp 1/1, same product -> 32'h00000000 underflow=1; product=0, signs 1/0 -> 32'h80000000, flags 0.
- Handshake: strobe held high 8 cycles -> exactly 2 results, done pulses 4 cycles apart; strobe during busy with different data -> ignored; rst asserted in ROUND -> no done, all outputs 0 next cycle, next strobe processes normally.

Source files
------------

// File: rtl/fp_mult_round_pack_if.sv
// rtl/fp_mult_round_pack_if.sv - start/done and data bundle for the FP32 post-multiply stage
interface fp_mult_round_pack_if;
  logic        round_input_ready;
  logic [47:0] product;
  logic        sign_a;
  logic        sign_b;
  logic [7:0]  exp_a;
  logic [7:0]  exp_b;
  logic [31:0] result;
  logic        round_output_ready;
  logic        busy;
  logic        overflow;
  logic        underflow;
  logic        inexact;

  modport master (
    output round_input_ready, product, sign_a, sign_b, exp_a, exp_b,
    input  result, round_output_ready, busy, overflow, underflow, inexact
  );

  modport slave (
    input  round_input_ready, product, sign_a, sign_b, exp_a, exp_b,
    output result, round_output_ready, busy, overflow, underflow, inexact
  );
endinterface

// File: rtl/fp_mult_round_pack.sv
// rtl/fp_mult_round_pack.sv - FP32 normalize, round-to-nearest-even and pack, one result per 4 cycles
module fp_mult_round_pack (
  input  logic                       clk,
  input  logic                       rst,
  fp_mult_round_pack_if.slave        bus
);

  typedef enum logic [1:0] {S_IDLE, S_NORM, S_ROUND, S_PACK} state_t;

  state_t             state_q, state_d;
  logic               sign_q, sign_d;
  logic signed [9:0]  exp_q, exp_d;
  logic [47:0]        prod_q, prod_d;
  logic [22:0]        frac_q, frac_d;
  logic               guard_q, guard_d;
  logic               sticky_q, sticky_d;
  logic               zero_q, zero_d;
  logic               rnd_inexact_q, rnd_inexact_d;
  logic [31:0]        result_q, result_d;
  logic               done_q, done_d;
  logic               overflow_q, overflow_d;
  logic               underflow_q, underflow_d;
  logic               inexact_q, inexact_d;

  logic               round_up;
  logic [23:0]        rounded;

  // State register and datapath flops; reset aborts any operation in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      sign_q        <= 1'b0;
      exp_q         <= '0;
      prod_q        <= '0;
      frac_q        <= '0;
      guard_q       <= 1'b0;
      sticky_q      <= 1'b0;
      zero_q        <= 1'b0;
      rnd_inexact_q <= 1'b0;
      result_q      <= '0;
      done_q        <= 1'b0;
      overflow_q    <= 1'b0;
      underflow_q   <= 1'b0;
      inexact_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      sign_q        <= sign_d;
      exp_q         <= exp_d;
      prod_q        <= prod_d;
      frac_q        <= frac_d;
      guard_q       <= guard_d;
      sticky_q      <= sticky_d;
      zero_q        <= zero_d;
      rnd_inexact_q <= rnd_inexact_d;
      result_q      <= result_d;
      done_q        <= done_d;
      overflow_q    <= overflow_d;
      underflow_q   <= underflow_d;
      inexact_q     <= inexact_d;
    end
  end

  // Next-state and per-stage datapath: capture, normalize, round, pack
  always_comb begin
    state_d       = state_q;
    sign_d        = sign_q;
    exp_d         = exp_q;
    prod_d        = prod_q;
    frac_d        = frac_q;
    guard_d       = guard_q;
    sticky_d      = sticky_q;
    zero_d        = zero_q;
    rnd_inexact_d = rnd_inexact_q;
    result_d      = result_q;
    overflow_d    = overflow_q;
    underflow_d   = underflow_q;
    inexact_d     = inexact_q;
    done_d        = 1'b0;
    round_up      = guard_q & (sticky_q | frac_q[0]);
    rounded       = {1'b0, frac_q} + {23'b0, round_up};

    case (state_q)
      S_IDLE: begin
        if (bus.round_input_ready) begin
          sign_d  = bus.sign_a ^ bus.sign_b;
          // 10-bit signed sum covers -127..383 without wrapping
          exp_d   = $signed({2'b00, bus.exp_a}) + $signed({2'b00, bus.exp_b}) - 10'sd127;
          prod_d  = bus.product;
          state_d = S_NORM;
        end
      end
      S_NORM: begin
        zero_d = (prod_q == 48'd0);
        if (prod_q[47]) begin
          frac_d   = prod_q[46:24];
          guard_d  = prod_q[23];
          sticky_d = |prod_q[22:0];
          exp_d    = exp_q + 10'sd1;
        end else begin
          // Also covers products without bit 46 set: no further shifting
          frac_d   = prod_q[45:23];
          guard_d  = prod_q[22];
          sticky_d = |prod_q[21:0];
        end
        state_d = S_ROUND;
      end
      S_ROUND: begin
        if (rounded[23]) begin
          frac_d = '0;
          exp_d  = exp_q + 10'sd1;
        end else begin
          frac_d = rounded[22:0];
        end
        rnd_inexact_d = guard_q | sticky_q;
        state_d       = S_PACK;
      end
      S_PACK: begin
        if (zero_q) begin
          result_d    = {sign_q, 31'b0};
          overflow_d  = 1'b0;
          underflow_d = 1'b0;
          inexact_d   = 1'b0;
        end else if (exp_q >= 10'sd255) begin
          result_d    = {sign_q, 8'hFF, 23'b0};
          overflow_d  = 1'b1;
          underflow_d = 1'b0;
          inexact_d   = 1'b1;
        end else if (exp_q <= 10'sd0) begin
          result_d    = {sign_q, 31'b0};
          overflow_d  = 1'b0;
          underflow_d = 1'b1;
          inexact_d   = 1'b1;
        end else begin
          result_d    = {sign_q, exp_q[7:0], frac_q};
          overflow_d  = 1'b0;
          underflow_d = 1'b0;
          inexact_d   = rnd_inexact_q;
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.result             = result_q;
  assign bus.round_output_ready = done_q;
  assign bus.busy               = (state_q != S_IDLE);
  assign bus.overflow           = overflow_q;
  assign bus.underflow          = underflow_q;
  assign bus.inexact            = inexact_q;

endmodule

// File: tb/tb_fp_mult_round_pack.sv
// tb/tb_fp_mult_round_pack.sv - randomized and directed bench for fp_mult_round_pack
module tb_fp_mult_round_pack;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fp_mult_round_pack_if bus();

  fp_mult_round_pack dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: value-level rounding on the integer product, flags = {overflow, underflow, inexact}
  task automatic model(input logic [47:0] p, input logic sa, input logic sb,
                       input logic [7:0] ea, input logic [7:0] eb,
                       output logic [31:0] r, output logic [2:0] fl);
    int e;
    int sh;
    logic s;
    longint unsigned pp, q, rem, half, f;
    bit rup;
    s  = sa ^ sb;
    e  = int'(ea) + int'(eb) - 127;
    pp = 64'(p);
    if (pp == 0) begin
      r  = {s, 31'b0};
      fl = 3'b000;
    end else begin
      sh = (pp >= 64'h800000000000) ? 24 : 23;
      if (sh == 24) e = e + 1;
      q    = pp >> sh;
      rem  = pp - (q << sh);
      half = 64'd1 << (sh - 1);
      f    = q % (64'd1 << 23);
      rup  = (rem > half) || (rem == half && (f % 2) == 1);
      f    = f + (rup ? 64'd1 : 64'd0);
      if (f == (64'd1 << 23)) begin
        f = 0;
        e = e + 1;
      end
      if (e >= 255) begin
        r  = {s, 8'hFF, 23'b0};
        fl = 3'b101;
      end else if (e <= 0) begin
        r  = {s, 31'b0};
        fl = 3'b011;
      end else begin
        r  = {s, e[7:0], f[22:0]};
        fl = {2'b00, rem != 0};
      end
    end
  endtask

  task automatic drive(input logic [47:0] p, input logic sa, input logic sb,
                       input logic [7:0] ea, input logic [7:0] eb);
    bus.product = p;
    bus.sign_a  = sa;
    bus.sign_b  = sb;
    bus.exp_a   = ea;
    bus.exp_b   = eb;
  endtask

  function automatic logic [31:0] outs();
    return {26'b0, bus.round_output_ready, bus.busy, bus.overflow, bus.underflow, bus.inexact, 1'b0};
  endfunction

  task automatic run_op(input string tag, input logic [47:0] p, input logic sa, input logic sb,
                        input logic [7:0] ea, input logic [7:0] eb);
    logic [31:0] er;
    logic [2:0]  ef;
    int cyc;
    bit got;
    model(p, sa, sb, ea, eb, er, ef);
    @(negedge clk);
    drive(p, sa, sb, ea, eb);
    bus.round_input_ready = 1'b1;
    got = 0;
    cyc = 0;
    for (int i = 0; i < 12 && !got; i++) begin
      @(negedge clk);
      bus.round_input_ready = 1'b0;
      cyc++;
      if (i == 0) check({tag, "_busy"}, 32'(bus.busy), 32'd1);
      if (bus.round_output_ready) got = 1;
    end
    check({tag, "_done"}, 32'(got), 32'd1);
    check({tag, "_latency"}, 32'(cyc), 32'd4);
    check({tag, "_result"}, bus.result, er);
    check({tag, "_flags"}, {29'b0, bus.overflow, bus.underflow, bus.inexact}, {29'b0, ef});
    check({tag, "_idle"}, 32'(bus.busy), 32'd0);
    @(negedge clk);
    check({tag, "_pulse"}, 32'(bus.round_output_ready), 32'd0);
  endtask

  initial begin
    logic [31:0] er;
    logic [2:0]  ef;
    logic [47:0] p;
    logic [7:0]  ea, eb;
    int n, t1, t2, mode;

    rst = 1'b1;
    bus.round_input_ready = 1'b0;
    drive(48'd0, 1'b0, 1'b0, 8'd0, 8'd0);
    repeat (3) @(negedge clk);
    check("reset_result", bus.result, 32'd0);
    check("reset_ctrl", outs(), 32'd0);
    rst = 1'b0;

    run_op("one_x_one",  48'h400000000000, 1'b0, 1'b0, 8'd127, 8'd127);
    run_op("bit47_path", 48'h900000000000, 1'b0, 1'b1, 8'd127, 8'd127);
    run_op("tie_odd",    48'h400000C00000, 1'b0, 1'b0, 8'd127, 8'd127);
    run_op("tie_even",   48'h400000400000, 1'b0, 1'b0, 8'd127, 8'd127);
    run_op("rnd_carry",  48'h7FFFFFC00000, 1'b0, 1'b0, 8'd127, 8'd127);
    run_op("overflow",   48'h400000000000, 1'b0, 1'b0, 8'd254, 8'd254);
    run_op("underflow",  48'h400000000000, 1'b0, 1'b0, 8'd1,   8'd1);
    run_op("neg_zero",   48'h000000000000, 1'b1, 1'b0, 8'd127, 8'd127);
    run_op("denorm_in",  48'h100000000001, 1'b1, 1'b1, 8'd130, 8'd120);

    // Strobe held for 8 edges: two results, 4 cycles apart
    @(negedge clk);
    drive(48'h400000000000, 1'b0, 1'b0, 8'd127, 8'd127);
    bus.round_input_ready = 1'b1;
    n = 0; t1 = -1; t2 = -1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == 7) bus.round_input_ready = 1'b0;
      if (bus.round_output_ready) begin
        n++;
        if (t1 < 0) t1 = i; else t2 = i;
      end
    end
    check("held_count", 32'(n), 32'd2);
    check("held_spacing", 32'(t2 - t1), 32'd4);
    check("held_result", bus.result, 32'h3F800000);

    // Strobe with new data while busy is dropped
    model(48'h900000000000, 1'b0, 1'b1, 8'd127, 8'd127, er, ef);
    @(negedge clk);
    drive(48'h900000000000, 1'b0, 1'b1, 8'd127, 8'd127);
    bus.round_input_ready = 1'b1;
    @(negedge clk);
    drive(48'h7FFFFFC00000, 1'b0, 1'b0, 8'd200, 8'd200);
    repeat (2) @(negedge clk);
    @(negedge clk);
    bus.round_input_ready = 1'b0;
    check("busy_drop_done", 32'(bus.round_output_ready), 32'd1);
    check("busy_drop_result", bus.result, er);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.round_output_ready) n++;
    end
    check("busy_drop_extra", 32'(n), 32'd0);

    // Reset while in ROUND aborts without a done pulse
    @(negedge clk);
    drive(48'h400000C00000, 1'b0, 1'b0, 8'd127, 8'd127);
    bus.round_input_ready = 1'b1;
    @(negedge clk);
    bus.round_input_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_result", bus.result, 32'd0);
    check("abort_ctrl", outs(), 32'd0);
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.round_output_ready) n++;
    end
    check("abort_no_done", 32'(n), 32'd0);
    run_op("after_abort", 48'h400000C00000, 1'b0, 1'b0, 8'd127, 8'd127);

    // Randomized operands, biased toward ties and in-range exponents
    for (int k = 0; k < 150; k++) begin
      p = {16'($urandom), 32'($urandom)};
      mode = $urandom_range(0, 9);
      case (mode)
        0: p = 48'd0;
        1: begin p[47:46] = 2'b01; p[22:0] = 23'h400000; end
        2: begin p[47] = 1'b1; p[23:0] = 24'h800000; end
        3: p[47:46] = 2'b00;
        default: if ($urandom_range(0, 1) == 1) p[47] = 1'b1; else p[47:46] = 2'b01;
      endcase
      if ($urandom_range(0, 1) == 1) begin
        ea = 8'($urandom_range(0, 255));
        eb = 8'($urandom_range(0, 255));
      end else begin
        ea = 8'($urandom_range(90, 165));
        eb = 8'($urandom_range(90, 165));
      end
      run_op("rand", p, 1'($urandom), 1'($urandom), ea, eb);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
